// File: rtl/bus_grant_arbiter_if.sv
// Signal bundle between the cycle FSM / Pi control side and the bus grant arbiter.
// The arbiter takes the slave modport; the driver of requests and strobes takes master.
interface bus_grant_arbiter_if;
    logic MCCLK_FALLING;
    logic ENABLE;
    logic nBR_IN;
    logic nBGACK_IN;
    logic nAS_IN;
    logic CYCLE_REQ;
    logic CYCLE_BUSY;
    logic CYCLE_GO;
    logic BG_DRIVE;
    logic EXT_OWNER;
    logic TIMEOUT_ERR;
    logic TIMEOUT_CLR;

    modport slave (
        input  MCCLK_FALLING, ENABLE, nBR_IN, nBGACK_IN, nAS_IN,
        input  CYCLE_REQ, CYCLE_BUSY, TIMEOUT_CLR,
        output CYCLE_GO, BG_DRIVE, EXT_OWNER, TIMEOUT_ERR
    );

    modport master (
        output MCCLK_FALLING, ENABLE, nBR_IN, nBGACK_IN, nAS_IN,
        output CYCLE_REQ, CYCLE_BUSY, TIMEOUT_CLR,
        input  CYCLE_GO, BG_DRIVE, EXT_OWNER, TIMEOUT_ERR
    );
endinterface

// File: rtl/bus_grant_arbiter.sv
// 68000 BR/BG/BGACK arbiter: hands the Amiga bus to external DMA masters between
// PiStorm cycles and reclaims it once BGACK releases, with a grant timeout.
module bus_grant_arbiter #(
    parameter int SYNC_STAGES   = 2,
    parameter int GRANT_TIMEOUT = 255,
    parameter int CNT_W         = 8
) (
    input  logic                 SYSCLK,
    input  logic                 RESET,
    bus_grant_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PENDING,
        S_GRANTED,
        S_EXTERNAL,
        S_RECLAIM
    } state_t;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(GRANT_TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] r_br_sync;
    logic [SYNC_STAGES-1:0] r_bgack_sync;
    logic [SYNC_STAGES-1:0] r_as_sync;

    state_t           r_state;
    state_t           w_next;
    logic             w_timeout;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bg;
    logic             r_ext;
    logic             r_err;

    logic w_br_s;
    logic w_bgack_s;
    logic w_as_s;

    // Synchronisers idle at the negated (high) level so reset looks like "no request".
    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            r_br_sync    <= '1;
            r_bgack_sync <= '1;
            r_as_sync    <= '1;
        end else begin
            r_br_sync    <= {r_br_sync[SYNC_STAGES-2:0], bus.nBR_IN};
            r_bgack_sync <= {r_bgack_sync[SYNC_STAGES-2:0], bus.nBGACK_IN};
            r_as_sync    <= {r_as_sync[SYNC_STAGES-2:0], bus.nAS_IN};
        end
    end

    assign w_br_s    = ~r_br_sync[SYNC_STAGES-1];
    assign w_bgack_s = ~r_bgack_sync[SYNC_STAGES-1];
    assign w_as_s    = ~r_as_sync[SYNC_STAGES-1];

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        if (bus.MCCLK_FALLING) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.ENABLE && w_br_s)
                        w_next = bus.CYCLE_BUSY ? S_PENDING : S_GRANTED;
                end
                S_PENDING: begin
                    if (!w_br_s || !bus.ENABLE) w_next = S_IDLE;
                    else if (!bus.CYCLE_BUSY)   w_next = S_GRANTED;
                end
                S_GRANTED: begin
                    // Acknowledge only counts once the previous owner's AS has gone away.
                    if (w_bgack_s && !w_as_s)        w_next = S_EXTERNAL;
                    else if (!w_br_s && !w_bgack_s)  w_next = S_RECLAIM;
                    else if (!bus.ENABLE)            w_next = S_RECLAIM;
                    else if (r_cnt == LP_LAST) begin
                        w_next    = S_RECLAIM;
                        w_timeout = 1'b1;
                    end
                end
                S_EXTERNAL: begin
                    if (!w_bgack_s) w_next = S_RECLAIM;
                end
                S_RECLAIM: w_next = S_IDLE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_bg    <= 1'b0;
            r_ext   <= 1'b0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_bg    <= (w_next == S_GRANTED);
            r_ext   <= (w_next == S_EXTERNAL) || (w_next == S_RECLAIM);
            if (w_next == S_GRANTED && r_state != S_GRANTED)
                r_cnt <= '0;
            else if (r_state == S_GRANTED && bus.MCCLK_FALLING && r_cnt != '1)
                r_cnt <= r_cnt + 1'b1;
            if (w_timeout)
                r_err <= 1'b1;
            else if (bus.TIMEOUT_CLR)
                r_err <= 1'b0;
        end
    end

    assign bus.CYCLE_GO    = bus.CYCLE_REQ && (r_state == S_IDLE) && !(bus.ENABLE && w_br_s);
    assign bus.BG_DRIVE    = r_bg;
    assign bus.EXT_OWNER   = r_ext;
    assign bus.TIMEOUT_ERR = r_err;

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Bench for bus_grant_arbiter: directed scenarios plus randomized bus-clock steps
// checked against a strobe-level ownership model.
module tb_bus_grant_arbiter;

    localparam int SS = 2;
    localparam int TO = 4;

    localparam int OWN_PI      = 0;
    localparam int OWN_WAIT    = 1;
    localparam int OWN_OFFERED = 2;
    localparam int OWN_EXT     = 3;
    localparam int OWN_GUARD   = 4;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    int   m_owner;
    int   m_offer_strobes;
    logic m_err;

    bus_grant_arbiter_if bif ();

    bus_grant_arbiter #(
        .SYNC_STAGES   (SS),
        .GRANT_TIMEOUT (TO),
        .CNT_W         (8)
    ) dut (
        .SYSCLK (clk),
        .RESET  (rst),
        .bus    (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_go();
        return bif.CYCLE_REQ && (m_owner == OWN_PI) && !(bif.ENABLE && !bif.nBR_IN);
    endfunction

    function automatic logic exp_bg();
        return m_owner == OWN_OFFERED;
    endfunction

    function automatic logic exp_ext();
        return (m_owner == OWN_EXT) || (m_owner == OWN_GUARD);
    endfunction

    task automatic model_reset();
        m_owner         = OWN_PI;
        m_offer_strobes = 0;
        m_err           = 1'b0;
    endtask

    // One bus-clock decision, applied to the (settled) pad levels.
    task automatic model_update(input logic clr);
        logic br, ack, as_l, set_err;
        br      = !bif.nBR_IN;
        ack     = !bif.nBGACK_IN;
        as_l    = !bif.nAS_IN;
        set_err = 1'b0;
        if (m_owner == OWN_PI) begin
            if (bif.ENABLE && br) begin
                m_owner         = bif.CYCLE_BUSY ? OWN_WAIT : OWN_OFFERED;
                m_offer_strobes = 0;
            end
        end else if (m_owner == OWN_WAIT) begin
            if (!br || !bif.ENABLE) m_owner = OWN_PI;
            else if (!bif.CYCLE_BUSY) begin
                m_owner         = OWN_OFFERED;
                m_offer_strobes = 0;
            end
        end else if (m_owner == OWN_OFFERED) begin
            m_offer_strobes++;
            if (ack && !as_l)                m_owner = OWN_EXT;
            else if (!br && !ack)            m_owner = OWN_GUARD;
            else if (!bif.ENABLE)            m_owner = OWN_GUARD;
            else if (m_offer_strobes >= TO) begin
                m_owner = OWN_GUARD;
                set_err = 1'b1;
            end
        end else if (m_owner == OWN_EXT) begin
            if (!ack) m_owner = OWN_GUARD;
        end else begin
            m_owner = OWN_PI;
        end
        if (set_err)  m_err = 1'b1;
        else if (clr) m_err = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic br_n, input logic ack_n, input logic as_n,
                         input logic en, input logic busy, input logic req);
        bif.nBR_IN     = br_n;
        bif.nBGACK_IN  = ack_n;
        bif.nAS_IN     = as_n;
        bif.ENABLE     = en;
        bif.CYCLE_BUSY = busy;
        bif.CYCLE_REQ  = req;
    endtask

    task automatic settle();
        repeat (SS + 1) tick();
    endtask

    task automatic strobe(input logic clr);
        bif.MCCLK_FALLING = 1'b1;
        bif.TIMEOUT_CLR   = clr;
        tick();
        bif.MCCLK_FALLING = 1'b0;
        bif.TIMEOUT_CLR   = 1'b0;
        model_update(clr);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        bif.MCCLK_FALLING = 1'b0;
        bif.TIMEOUT_CLR   = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        n_tests++;
        if ({bif.BG_DRIVE, bif.EXT_OWNER, bif.TIMEOUT_ERR, bif.CYCLE_GO} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0000",
                     {bif.BG_DRIVE, bif.EXT_OWNER, bif.TIMEOUT_ERR, bif.CYCLE_GO});
        end
        rst = 1'b0;
        model_reset();
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        n_tests++;
        if (bif.CYCLE_GO !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_go_after_release: got %b expected 1", bif.CYCLE_GO);
        end
    endtask

    task automatic test_idle_handshake();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            bif.MCCLK_FALLING = (i % 4 == 0);
            tick();
            n_tests++;
            if (bif.CYCLE_GO !== 1'b1 || bif.BG_DRIVE !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_handshake[%0d]: got go=%b bg=%b expected go=1 bg=0",
                         i, bif.CYCLE_GO, bif.BG_DRIVE);
            end
        end
        bif.MCCLK_FALLING = 1'b0;
    endtask

    task automatic test_grant_busy();
        bit seen;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        settle();
        strobe(1'b0);
        n_tests++;
        if (bif.CYCLE_GO !== 1'b0 || bif.BG_DRIVE !== 1'b0) begin
            n_fail++;
            $display("FAIL pending_blocks: got go=%b bg=%b expected go=0 bg=0",
                     bif.CYCLE_GO, bif.BG_DRIVE);
        end
        bif.CYCLE_BUSY = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < SS + 1 && !seen; i++) begin
            strobe(1'b0);
            seen = (bif.BG_DRIVE === 1'b1);
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL grant_after_busy: got bg=%b expected 1 within %0d strobes",
                     bif.BG_DRIVE, SS + 1);
        end
        bif.nBGACK_IN = 1'b0;
        settle();
        strobe(1'b0);
        n_tests++;
        if (bif.BG_DRIVE !== 1'b0 || bif.EXT_OWNER !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_to_external: got bg=%b ext=%b expected bg=0 ext=1",
                     bif.BG_DRIVE, bif.EXT_OWNER);
        end
        bif.nBGACK_IN = 1'b1;
        bif.nBR_IN    = 1'b1;
        settle();
        strobe(1'b0);
        n_tests++;
        if (bif.EXT_OWNER !== 1'b1) begin
            n_fail++;
            $display("FAIL reclaim_guard: got ext=%b expected 1", bif.EXT_OWNER);
        end
        settle();
        strobe(1'b0);
        n_tests++;
        if (bif.EXT_OWNER !== 1'b0 || bif.CYCLE_GO !== 1'b1) begin
            n_fail++;
            $display("FAIL reclaim_done: got ext=%b go=%b expected ext=0 go=1",
                     bif.EXT_OWNER, bif.CYCLE_GO);
        end
    endtask

    task automatic test_as_hold();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        settle();
        strobe(1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            settle();
            strobe(1'b0);
            n_tests++;
            if (bif.BG_DRIVE !== 1'b1 || bif.EXT_OWNER !== 1'b0) begin
                n_fail++;
                $display("FAIL as_hold[%0d]: got bg=%b ext=%b expected bg=1 ext=0",
                         i, bif.BG_DRIVE, bif.EXT_OWNER);
            end
        end
        bif.nAS_IN = 1'b1;
        settle();
        strobe(1'b0);
        n_tests++;
        if (bif.BG_DRIVE !== 1'b0 || bif.EXT_OWNER !== 1'b1) begin
            n_fail++;
            $display("FAIL as_release: got bg=%b ext=%b expected bg=0 ext=1",
                     bif.BG_DRIVE, bif.EXT_OWNER);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        settle();
        strobe(1'b0);
        strobe(1'b0);
    endtask

    task automatic test_withdraw();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        settle();
        strobe(1'b0);
        bif.nBR_IN = 1'b1;
        settle();
        strobe(1'b0);
        n_tests++;
        if (bif.BG_DRIVE !== 1'b0 || bif.EXT_OWNER !== 1'b1 || bif.CYCLE_GO !== 1'b0) begin
            n_fail++;
            $display("FAIL withdraw_reclaim: got bg=%b ext=%b go=%b expected bg=0 ext=1 go=0",
                     bif.BG_DRIVE, bif.EXT_OWNER, bif.CYCLE_GO);
        end
        strobe(1'b0);
        n_tests++;
        if (bif.EXT_OWNER !== 1'b0 || bif.TIMEOUT_ERR !== 1'b0 || bif.CYCLE_GO !== 1'b1) begin
            n_fail++;
            $display("FAIL withdraw_idle: got ext=%b err=%b go=%b expected ext=0 err=0 go=1",
                     bif.EXT_OWNER, bif.TIMEOUT_ERR, bif.CYCLE_GO);
        end
    endtask

    task automatic test_timeout();
        for (int pass = 0; pass < 2; pass++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            settle();
            strobe(1'b0);
            for (int s = 1; s <= TO; s++) begin
                strobe((pass == 1) && (s == TO));
                n_tests++;
                if (bif.BG_DRIVE !== (s < TO)) begin
                    n_fail++;
                    $display("FAIL timeout_bg[p%0d s%0d]: got %b expected %b",
                             pass, s, bif.BG_DRIVE, (s < TO));
                end
            end
            n_tests++;
            if (bif.TIMEOUT_ERR !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout_err_set[p%0d]: got %b expected 1", pass, bif.TIMEOUT_ERR);
            end
            bif.nBR_IN = 1'b1;
            settle();
            strobe(1'b0);
            bif.TIMEOUT_CLR = 1'b1;
            tick();
            bif.TIMEOUT_CLR = 1'b0;
            m_err = 1'b0;
            n_tests++;
            if (bif.TIMEOUT_ERR !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_clr[p%0d]: got %b expected 0", pass, bif.TIMEOUT_ERR);
            end
        end
    endtask

    task automatic test_enable();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        settle();
        for (int i = 0; i < 3; i++) begin
            strobe(1'b0);
            n_tests++;
            if (bif.CYCLE_GO !== 1'b1 || bif.BG_DRIVE !== 1'b0) begin
                n_fail++;
                $display("FAIL disabled_no_grant[%0d]: got go=%b bg=%b expected go=1 bg=0",
                         i, bif.CYCLE_GO, bif.BG_DRIVE);
            end
        end
        bif.CYCLE_REQ = 1'b0;
        #1;
        n_tests++;
        if (bif.CYCLE_GO !== 1'b0) begin
            n_fail++;
            $display("FAIL disabled_go_follows_req: got %b expected 0", bif.CYCLE_GO);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        strobe(1'b0);
        bif.ENABLE = 1'b0;
        strobe(1'b0);
        n_tests++;
        if (bif.CYCLE_GO !== 1'b1 || bif.BG_DRIVE !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_drop_pending: got go=%b bg=%b expected go=1 bg=0",
                     bif.CYCLE_GO, bif.BG_DRIVE);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        strobe(1'b0);
        bif.ENABLE = 1'b0;
        strobe(1'b0);
        n_tests++;
        if (bif.BG_DRIVE !== 1'b0 || bif.EXT_OWNER !== 1'b1 || bif.TIMEOUT_ERR !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_drop_granted: got bg=%b ext=%b err=%b expected 0 1 0",
                     bif.BG_DRIVE, bif.EXT_OWNER, bif.TIMEOUT_ERR);
        end
        strobe(1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        strobe(1'b0);
        bif.nBGACK_IN = 1'b0;
        settle();
        strobe(1'b0);
        bif.ENABLE = 1'b0;
        for (int i = 0; i < 2; i++) begin
            strobe(1'b0);
            n_tests++;
            if (bif.EXT_OWNER !== 1'b1) begin
                n_fail++;
                $display("FAIL external_not_aborted[%0d]: got %b expected 1", i, bif.EXT_OWNER);
            end
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        settle();
        strobe(1'b0);
        rst = 1'b1;
        #2;
        n_tests++;
        if (bif.BG_DRIVE !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_granted: got bg=%b expected 0", bif.BG_DRIVE);
        end
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        settle();
        strobe(1'b0);
        bif.nBGACK_IN = 1'b0;
        settle();
        strobe(1'b0);
        rst = 1'b1;
        #2;
        n_tests++;
        if (bif.BG_DRIVE !== 1'b0 || bif.EXT_OWNER !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_external: got bg=%b ext=%b expected 0 0",
                     bif.BG_DRIVE, bif.EXT_OWNER);
        end
        do_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            drive(($urandom % 3) != 0 ? 1'b0 : 1'b1,
                  ($urandom % 3) != 0 ? 1'b1 : 1'b0,
                  1'($urandom % 2),
                  ($urandom % 8) != 0,
                  1'($urandom % 2),
                  1'($urandom % 2));
            settle();
            n_tests++;
            if (bif.CYCLE_GO !== exp_go()) begin
                n_fail++;
                $display("FAIL rand_go[%0d]: got %b expected %b", i, bif.CYCLE_GO, exp_go());
            end
            strobe(($urandom % 8) == 0);
            n_tests++;
            if ({bif.BG_DRIVE, bif.EXT_OWNER, bif.TIMEOUT_ERR} !== {exp_bg(), exp_ext(), m_err}) begin
                n_fail++;
                $display("FAIL rand_state[%0d]: got bg/ext/err=%b expected %b", i,
                         {bif.BG_DRIVE, bif.EXT_OWNER, bif.TIMEOUT_ERR},
                         {exp_bg(), exp_ext(), m_err});
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        bif.MCCLK_FALLING = 1'b0;
        bif.TIMEOUT_CLR   = 1'b0;
        model_reset();
        test_reset();
        test_idle_handshake();
        test_grant_busy();
        test_as_hold();
        test_withdraw();
        test_timeout();
        test_enable();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
